// File: rtl/dec_4x16_selftest_ctrl.sv
// Built-in self-test sequencer for a 4x16 decoder made of two 3x8 decoders.
// Sweeps select codes 0..15, holds each for SETTLE_CYCLES cycles, then checks
// that the decoder output is exactly one-hot at the selected position.
// Records a per-code fault map, a fault count and the first failing code/pattern.
module dec_4x16_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] D_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        W,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fault_map,
    output logic [4:0]  fault_count,
    output logic [3:0]  first_code,
    output logic [15:0] first_pattern
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] ONE_HOT_BASE = 16'h0001;

    state_t      state;
    state_t      next_state;
    logic [3:0]  code;
    logic [3:0]  settle_cnt;
    logic [3:0]  sel;
    logic [15:0] expected;
    logic        mismatch;
    logic        settle_done;
    logic        start_sweep;

    // Expected decoder response for the current code and the settle/start qualifiers
    always_comb begin
        expected    = ONE_HOT_BASE << code;
        mismatch    = (D_in != expected);
        settle_done = (settle_cnt == SETTLE_LAST);
        start_sweep = start && !abort && ((state == IDLE) || (state == DONE));
    end

    // State register; abort and reset both land in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs; abort overrides everything
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        sel        = 4'd0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = APPLY;
                APPLY:   if (settle_done) next_state = CHECK;
                CHECK:   next_state = (code == 4'd15) ? DONE : APPLY;
                DONE:    if (start) next_state = APPLY;
                default: next_state = IDLE;
            endcase
        end
        case (state)
            APPLY: begin
                busy = 1'b1;
                sel  = code;
            end
            CHECK: begin
                busy = 1'b1;
                sel  = code;
            end
            DONE: begin
                done = 1'b1;
                pass = (fault_count == 5'd0);
                sel  = code;
            end
            default: begin
                sel = 4'd0;
            end
        endcase
        {X, Y, Z, W} = sel;
    end

    // Sweep datapath: code/settle counters and fault bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code          <= 4'd0;
            settle_cnt    <= 4'd0;
            fault_map     <= 16'h0000;
            fault_count   <= 5'd0;
            first_code    <= 4'd0;
            first_pattern <= 16'h0000;
        end else if (abort) begin
            code       <= 4'd0;
            settle_cnt <= 4'd0;
        end else if (start_sweep) begin
            code          <= 4'd0;
            settle_cnt    <= 4'd0;
            fault_map     <= 16'h0000;
            fault_count   <= 5'd0;
            first_code    <= 4'd0;
            first_pattern <= 16'h0000;
        end else if (state == APPLY) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else if (state == CHECK) begin
            if (mismatch) begin
                fault_map[code] <= 1'b1;
                fault_count     <= fault_count + 5'd1;
                if (fault_count == 5'd0) begin
                    first_code    <= code;
                    first_pattern <= D_in;
                end
            end
            if (code != 4'd15) begin
                code       <= code + 4'd1;
                settle_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_dec_4x16_selftest_ctrl.sv
// Self-checking bench for dec_4x16_selftest_ctrl.
// A behavioural decoder model with selectable stuck-at faults drives D_in.
// Expected sweep results are queued when a sweep is started; a monitor pops
// and compares them when done rises, and also checks the busy duration.
module tb_dec_4x16_selftest_ctrl;

    typedef struct packed {
        logic [15:0] map;
        logic [4:0]  cnt;
        logic [3:0]  code;
        logic [15:0] pat;
        logic        pass;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] D_in;
    logic        X, Y, Z, W;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] fault_map;
    logic [4:0]  fault_count;
    logic [3:0]  first_code;
    logic [15:0] first_pattern;

    int          fault_mode;
    int          checks;
    int          errors;
    int          busy_cycles;
    logic        done_q;
    exp_t        sb[$];

    dec_4x16_selftest_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .D_in(D_in),
        .X(X),
        .Y(Y),
        .Z(Z),
        .W(W),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fault_map(fault_map),
        .fault_count(fault_count),
        .first_code(first_code),
        .first_pattern(first_pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: 0 good, 1 D[5] stuck-0, 2 upper 3x8 stuck-0, 3 D[3] stuck-1
    always_comb begin
        logic [15:0] good;
        logic [15:0] one;
        one  = 16'h0001;
        good = one << {X, Y, Z, W};
        case (fault_mode)
            1:       D_in = good & ~16'h0020;
            2:       D_in = good & 16'h00FF;
            3:       D_in = good | 16'h0008;
            default: D_in = good;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: on done rising, pop the expected result and compare; track busy length
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("fault_map", 32'(fault_map), 32'(e.map));
                checkOutput("fault_count", 32'(fault_count), 32'(e.cnt));
                checkOutput("first_code", 32'(first_code), 32'(e.code));
                checkOutput("first_pattern", 32'(first_pattern), 32'(e.pat));
                checkOutput("pass", 32'(pass), 32'(e.pass));
                checkOutput("done_sel_15", 32'({X, Y, Z, W}), 32'd15);
                checkOutput("busy_cycles", 32'(busy_cycles), 32'd48);
            end
            busy_cycles = 0;
        end else if (busy) begin
            busy_cycles++;
        end else begin
            busy_cycles = 0;
        end
        done_q = done;
    end

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Queue the expected results, then run one full sweep with the given fault model
    task automatic applyStimulus(input int mode, input exp_t e, input string name);
        fault_mode = mode;
        sb.push_back(e);
        pulseStart();
        waitDone(name);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sel"}, 32'({X, Y, Z, W}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_map"}, 32'(fault_map), 32'd0);
        checkOutput({tag, "_count"}, 32'(fault_count), 32'd0);
        checkOutput({tag, "_fcode"}, 32'(first_code), 32'd0);
        checkOutput({tag, "_fpat"}, 32'(first_pattern), 32'd0);
    endtask

    initial begin
        bit found;
        checks      = 0;
        errors      = 0;
        busy_cycles = 0;
        done_q      = 1'b0;
        fault_mode  = 0;
        start       = 1'b0;
        abort       = 1'b0;
        rst_n       = 1'b0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(0, '{map: 16'h0000, cnt: 5'd0, code: 4'd0, pat: 16'h0000, pass: 1'b1}, "t1_timeout");
        applyStimulus(1, '{map: 16'h0020, cnt: 5'd1, code: 4'd5, pat: 16'h0000, pass: 1'b0}, "t2_timeout");
        applyStimulus(2, '{map: 16'hFF00, cnt: 5'd8, code: 4'd8, pat: 16'h0000, pass: 1'b0}, "t3_timeout");
        applyStimulus(3, '{map: 16'hFFF7, cnt: 5'd15, code: 4'd0, pat: 16'h0009, pass: 1'b0}, "t4_timeout");

        // Abort on the first APPLY cycle of code 6 with D[5] stuck-0
        fault_mode = 1;
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && ({X, Y, Z, W} == 4'd6)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort_reach_code6", 32'(found), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sel", 32'({X, Y, Z, W}), 32'd0);
        checkOutput("abort_pass", 32'(pass), 32'd0);
        checkOutput("abort_keep_map", 32'(fault_map), 32'h0020);
        checkOutput("abort_keep_count", 32'(fault_count), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("abort_idle_hold", 32'(busy), 32'd0);

        // Fresh sweep after abort clears the partial results
        fault_mode = 0;
        sb.push_back('{map: 16'h0000, cnt: 5'd0, code: 4'd0, pat: 16'h0000, pass: 1'b1});
        pulseStart();
        @(negedge clk);
        checkOutput("restart_map_clear", 32'(fault_map), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        waitDone("t5_timeout");

        // Asynchronous reset in the middle of a sweep, away from any clock edge
        fault_mode = 2;
        pulseStart();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Extra start pulses while busy must not disturb the sweep or its latency
        fork
            applyStimulus(3, '{map: 16'hFFF7, cnt: 5'd15, code: 4'd0, pat: 16'h0009, pass: 1'b0}, "t6_timeout");
            begin
                for (int k = 0; k < 3; k++) begin
                    repeat (12) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            end
        join

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
